// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the mem port arbiter: FSM states, requester
// indices and small index helpers for the three-way rotation.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_ST_IDLE  = 2'd0,
        ARB_ST_ISSUE = 2'd1,
        ARB_ST_WAIT  = 2'd2
    } arb_state_e;

    localparam int         ARB_NREQ      = 3;
    localparam logic [1:0] ARB_REQ_FETCH = 2'd0;
    localparam logic [1:0] ARB_REQ_DATA  = 2'd1;
    localparam logic [1:0] ARB_REQ_EXT   = 2'd2;

    function automatic logic [1:0] arb_idx_inc(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [1:0] arb_idx_dec(input logic [1:0] i);
        return (i == 2'd0) ? 2'd2 : i - 2'd1;
    endfunction

    function automatic logic [1:0] arb_onehot_idx(input logic [ARB_NREQ-1:0] oh);
        logic [1:0] idx;
        idx = ARB_REQ_FETCH;
        if (oh[1]) idx = ARB_REQ_DATA;
        if (oh[2]) idx = ARB_REQ_EXT;
        return idx;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Combinational priority picker: scans the three requesters starting at
// 'start', upward or downward, and returns a one-hot winner (zero if no req).
module arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter bit ROTATE_UP = 1'b1
) (
    input  logic [ARB_NREQ-1:0] req,
    input  logic [1:0]          start,
    output logic [ARB_NREQ-1:0] grant
);

    logic [1:0] idx;

    always_comb begin
        grant = '0;
        idx   = start;
        for (int i = 0; i < ARB_NREQ; i++) begin
            if (grant == '0 && req[idx]) grant[idx] = 1'b1;
            idx = ROTATE_UP ? arb_idx_inc(idx) : arb_idx_dec(idx);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single mem port between fetch, data and ext requesters.
// Build option: define ARB_ROUND_ROBIN_EN for rotating priority (default 2 > 1 > 0).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ARB_NREQ-1:0] req,
    input  logic [15:0]         addr0,
    input  logic [15:0]         addr1,
    input  logic [15:0]         addr2,
    input  logic [ARB_NREQ-1:0] wr,
    input  logic [ARB_NREQ-1:0] byte_en,
    input  logic [15:0]         wdata0,
    input  logic [15:0]         wdata1,
    input  logic [15:0]         wdata2,
    output logic [ARB_NREQ-1:0] gnt,
    output logic [ARB_NREQ-1:0] ack,
    output logic                err,
    output logic [15:0]         rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic                mem_byte_enable,
    output logic                mem_byte_select,
    output logic [15:0]         mem_addr,
    output logic [15:0]         mem_wdata,
    input  logic [15:0]         mem_rdata,
    input  logic                mem_wait,
    output arb_state_e          state_dbg
);

    // Handshake: a requester holds req and its command stable until ack. The
    // command is captured at grant, so later changes (including dropping req)
    // are ignored; ack pulses for exactly one cycle, with err on timeout.

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    arb_state_e          state_q, state_d;
    logic [ARB_NREQ-1:0] gnt_q, ack_q, arb_gnt;
    logic                err_q;
    logic [15:0]         rdata_q;
    logic [7:0]          cnt_q;
    logic [15:0]         addr_q, wdata_q;
    logic                wr_q, be_q;
    logic [1:0]          arb_start, sel_idx;
    logic [15:0]         sel_addr, sel_wdata;
    logic                sel_wr, sel_be;
    logic                arb_go, wait_last;

    // The ack cycle is spent in IDLE without arbitrating, which guarantees a
    // full idle cycle between consecutive grants.
    assign arb_go    = (state_q == ARB_ST_IDLE) && (ack_q == '0) && (req != '0);
    assign wait_last = (cnt_q == WAIT_LAST);
    assign sel_idx   = arb_onehot_idx(arb_gnt);

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit ROTATE_UP = 1'b1;
    logic [1:0] ptr_q;

    // ptr_q sits two steps behind the start index, so its reset value of 0
    // gives ext top priority, the same first pick as the fixed build.
    always_ff @(posedge clk) begin
        if (!rst_n)      ptr_q <= 2'd0;
        else if (arb_go) ptr_q <= arb_idx_dec(sel_idx);
    end

    assign arb_start = arb_idx_dec(ptr_q);
`else
    localparam bit ROTATE_UP = 1'b0;
    assign arb_start = ARB_REQ_EXT;
`endif

    arb_prio #(.ROTATE_UP(ROTATE_UP)) u_arb_prio (
        .req   (req),
        .start (arb_start),
        .grant (arb_gnt)
    );

    always_comb begin
        sel_addr  = addr0;
        sel_wdata = wdata0;
        sel_wr    = wr[0];
        sel_be    = byte_en[0];
        case (sel_idx)
            ARB_REQ_DATA: begin
                sel_addr  = addr1;
                sel_wdata = wdata1;
                sel_wr    = wr[1];
                sel_be    = byte_en[1];
            end
            ARB_REQ_EXT: begin
                sel_addr  = addr2;
                sel_wdata = wdata2;
                sel_wr    = wr[2];
                sel_be    = byte_en[2];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            ARB_ST_IDLE: if (arb_go) state_d = ARB_ST_ISSUE;
            ARB_ST_ISSUE: begin
                mem_en  = 1'b1;
                mem_we  = wr_q;
                state_d = ARB_ST_WAIT;
            end
            ARB_ST_WAIT: begin
                mem_en = 1'b1;
                if (!mem_wait || wait_last) state_d = ARB_ST_IDLE;
            end
            default: state_d = ARB_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_ST_IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            be_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= '0;
            err_q   <= 1'b0;
            case (state_q)
                ARB_ST_IDLE: begin
                    if (arb_go) begin
                        gnt_q   <= arb_gnt;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        wr_q    <= sel_wr;
                        be_q    <= sel_be;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                ARB_ST_ISSUE: cnt_q <= '0;
                ARB_ST_WAIT: begin
                    if (!mem_wait) begin
                        ack_q   <= gnt_q;
                        rdata_q <= mem_rdata;
                    end else if (wait_last) begin
                        ack_q <= gnt_q;
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt             = gnt_q;
    assign ack             = ack_q;
    assign err             = err_q;
    assign rdata           = rdata_q;
    assign mem_byte_enable = be_q;
    assign mem_byte_select = addr_q[0];
    assign mem_addr        = {1'b0, addr_q[15:1]};
    assign mem_wdata       = wdata_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: addressing, grant order, timeout, reset
// abandonment and req drop/re-assert timing, all against hand-computed values.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = '0, wr = '0, byte_en = '0;
    logic [15:0] addr0 = '0, addr1 = '0, addr2 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0, wdata2 = '0;
    logic [2:0]  gnt, ack;
    logic        err, mem_en, mem_we, mem_byte_enable, mem_byte_select;
    logic [15:0] rdata, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_wait = 1'b0;
    arb_state_e  state_dbg;
    logic [2:0]  exp_g [3];

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wr(wr), .byte_en(byte_en),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_byte_enable(mem_byte_enable), .mem_byte_select(mem_byte_select),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_wait(mem_wait), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%04h exp=0x%04h", tag, got, exp);
        end
    endtask

    // Outputs are sampled and inputs driven 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_g[0] = 3'b100; exp_g[1] = 3'b001; exp_g[2] = 3'b010;
`else
        exp_g[0] = 3'b100; exp_g[1] = 3'b100; exp_g[2] = 3'b100;
`endif
        tick();
        tick();
        check_eq("rst_gnt", 16'(gnt), 16'h0);
        check_eq("rst_ack", 16'(ack), 16'h0);
        check_eq("rst_err", 16'(err), 16'h0);
        check_eq("rst_rdata", rdata, 16'h0);
        check_eq("rst_mem_en", 16'(mem_en), 16'h0);
        check_eq("rst_mem_we", 16'(mem_we), 16'h0);
        check_eq("rst_mem_addr", mem_addr, 16'h0);
        check_eq("rst_state", 16'(state_dbg), 16'(ARB_ST_IDLE));
        rst_n = 1'b1;
        tick();

        // fetch read at byte 0x0010
        req = 3'b001; addr0 = 16'h0010; mem_rdata = 16'hBEEF;
        tick();
        check_eq("t1_state_issue", 16'(state_dbg), 16'(ARB_ST_ISSUE));
        check_eq("t1_gnt", 16'(gnt), 16'h0001);
        check_eq("t1_mem_en", 16'(mem_en), 16'h1);
        check_eq("t1_mem_we", 16'(mem_we), 16'h0);
        check_eq("t1_mem_addr", mem_addr, 16'h0008);
        check_eq("t1_bsel", 16'(mem_byte_select), 16'h0);
        tick();
        check_eq("t1_wait_en", 16'(mem_en), 16'h1);
        check_eq("t1_wait_ack", 16'(ack), 16'h0);
        tick();
        check_eq("t1_ack", 16'(ack), 16'h0001);
        check_eq("t1_rdata", rdata, 16'hBEEF);
        check_eq("t1_err", 16'(err), 16'h0);
        check_eq("t1_gnt_ackcyc", 16'(gnt), 16'h0001);
        req = 3'b000;
        tick();
        check_eq("t1_ack_gone", 16'(ack), 16'h0);
        check_eq("t1_gnt_gone", 16'(gnt), 16'h0);

        // data byte write to odd address; command change after grant ignored
        req = 3'b010; wr = 3'b010; byte_en = 3'b010; addr1 = 16'h0021; wdata1 = 16'h00AA;
        mem_rdata = 16'h1234;
        tick();
        check_eq("t2_gnt", 16'(gnt), 16'h0002);
        check_eq("t2_mem_we", 16'(mem_we), 16'h1);
        check_eq("t2_bena", 16'(mem_byte_enable), 16'h1);
        check_eq("t2_bsel", 16'(mem_byte_select), 16'h1);
        check_eq("t2_mem_addr", mem_addr, 16'h0010);
        check_eq("t2_mem_wdata", mem_wdata, 16'h00AA);
        addr1 = 16'h0F00; wdata1 = 16'h5555;
        tick();
        check_eq("t2_wait_we", 16'(mem_we), 16'h0);
        check_eq("t2_addr_held", mem_addr, 16'h0010);
        check_eq("t2_wdata_held", mem_wdata, 16'h00AA);
        tick();
        check_eq("t2_ack", 16'(ack), 16'h0002);
        check_eq("t2_rdata", rdata, 16'h1234);
        req = 3'b000; wr = 3'b000; byte_en = 3'b000;
        tick();
        check_eq("t2_idle_en", 16'(mem_en), 16'h0);
        check_eq("t2_idle_addr", mem_addr, 16'h0010);

        // all three requesting for three transactions
        req = 3'b111; addr0 = 16'h0100; addr1 = 16'h0200; addr2 = 16'h0300;
        for (int t = 0; t < 3; t++) begin
            tick();
            check_eq($sformatf("t3_gnt%0d", t), 16'(gnt), 16'(exp_g[t]));
            tick();
            tick();
            check_eq($sformatf("t3_ack%0d", t), 16'(ack), 16'(exp_g[t]));
            tick();
            check_eq($sformatf("t3_idle%0d", t), 16'(gnt), 16'h0);
            if (t == 2) req = 3'b000;
        end
        tick();
        check_eq("t3_no_more", 16'(gnt), 16'h0);

        // timeout: mem_wait stuck high, MAX_WAIT=4
        req = 3'b001; addr0 = 16'h0002; mem_wait = 1'b1;
        tick();
        tick();
        tick();
        tick();
        tick();
        check_eq("t4_w4_state", 16'(state_dbg), 16'(ARB_ST_WAIT));
        check_eq("t4_w4_ack", 16'(ack), 16'h0);
        tick();
        check_eq("t4_ack", 16'(ack), 16'h0001);
        check_eq("t4_err", 16'(err), 16'h1);
        check_eq("t4_state", 16'(state_dbg), 16'(ARB_ST_IDLE));
        req = 3'b000; mem_wait = 1'b0;
        tick();
        check_eq("t4_err_gone", 16'(err), 16'h0);
        req = 3'b100; addr2 = 16'h0102; mem_rdata = 16'h5A5A;
        tick();
        check_eq("t4_next_gnt", 16'(gnt), 16'h0004);
        check_eq("t4_next_addr", mem_addr, 16'h0081);
        tick();
        tick();
        check_eq("t4_next_ack", 16'(ack), 16'h0004);
        check_eq("t4_next_err", 16'(err), 16'h0);
        check_eq("t4_next_rdata", rdata, 16'h5A5A);
        req = 3'b000;
        tick();

        // reset during WAIT abandons the access
        req = 3'b010; addr1 = 16'h0040; mem_wait = 1'b1;
        tick();
        tick();
        check_eq("t5_in_wait", 16'(state_dbg), 16'(ARB_ST_WAIT));
        rst_n = 1'b0;
        tick();
        check_eq("t5_gnt", 16'(gnt), 16'h0);
        check_eq("t5_mem_en", 16'(mem_en), 16'h0);
        check_eq("t5_ack", 16'(ack), 16'h0);
        check_eq("t5_state", 16'(state_dbg), 16'(ARB_ST_IDLE));
        rst_n = 1'b1; req = 3'b000; mem_wait = 1'b0;
        tick();
        check_eq("t5_no_ack", 16'(ack), 16'h0);
        req = 3'b010; mem_rdata = 16'h7777;
        tick();
        check_eq("t5_fresh_gnt", 16'(gnt), 16'h0002);
        tick();
        tick();
        check_eq("t5_fresh_ack", 16'(ack), 16'h0002);
        check_eq("t5_fresh_rdata", rdata, 16'h7777);
        req = 3'b000;
        tick();

        // req dropped in ISSUE still completes; re-asserted in ack cycle
        req = 3'b001; addr0 = 16'h0006; mem_rdata = 16'h0C0C;
        tick();
        check_eq("t6_gnt", 16'(gnt), 16'h0001);
        req = 3'b000;
        tick();
        tick();
        check_eq("t6_ack", 16'(ack), 16'h0001);
        check_eq("t6_rdata", rdata, 16'h0C0C);
        req = 3'b001;
        tick();
        check_eq("t6_idle_gap", 16'(gnt), 16'h0);
        check_eq("t6_idle_state", 16'(state_dbg), 16'(ARB_ST_IDLE));
        tick();
        check_eq("t6_regrant", 16'(gnt), 16'h0001);
        check_eq("t6_regrant_state", 16'(state_dbg), 16'(ARB_ST_ISSUE));
        tick();
        tick();
        check_eq("t6_ack2", 16'(ack), 16'h0001);
        req = 3'b000;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
